// File: rtl/game_logic.sv
// Snake game core: segment positions, stepping, eating, collisions and per-pixel colour.
// Define GAME_LOGIC_WRAP_EN to make the head wrap around the field edges instead of ending the game.
module game_logic #(
    parameter int MAX_LEN = 16,
    parameter int CELL    = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_reduced,
    input  logic        mover,
    input  logic [10:0] pixel_x,
    input  logic [10:0] pixel_y,
    input  logic        izquierda,
    input  logic        derecha,
    input  logic        arriba,
    input  logic        abajo,
    input  logic [2:0]  accion,
    input  logic [2:0]  r_fruta,
    input  logic [2:0]  g_fruta,
    input  logic [1:0]  b_fruta,
    input  logic [11:0] fruit_x,
    input  logic [11:0] fruit_y,
    output logic [2:0]  r_out,
    output logic [2:0]  g_out,
    output logic [1:0]  b_out,
    output logic        comer
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam logic [11:0] CELL_P = 12'(CELL);
    localparam logic [11:0] X_LAST = 12'(800 - CELL);
    localparam logic [11:0] Y_LAST = 12'(600 - CELL);
    localparam logic [11:0] X0     = 12'd400;
    localparam logic [11:0] Y0     = 12'd300;
    localparam logic [LEN_W-1:0] LEN_INIT = LEN_W'(3);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;
    typedef enum logic {ST_PLAY, ST_OVER} state_t;

    logic [11:0]      seg_x [MAX_LEN];
    logic [11:0]      seg_y [MAX_LEN];
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] check_len;
    dir_t             last_dir;
    dir_t             cmd_dir;
    dir_t             eff_dir;
    state_t           state;
    state_t           state_next;
    logic             game_over;
    logic             cmd_valid;
    logic             step_req;
    logic             step_ok;
    logic             collide;
    logic             hit_wall;
    logic             self_hit;
    logic             eat;
    logic             grow;
    logic [11:0]      new_x;
    logic [11:0]      new_y;
    logic [3:0]       btn;
    logic [3:0]       btn_prev;
    logic             btn_rise;
    logic             restart;
    logic [11:0]      pix_x;
    logic [11:0]      pix_y;
    logic             in_head;
    logic             in_body;
    logic             in_fruit;
    logic [7:0]       rgb_next;

    function automatic logic in_cell(input logic [11:0] px, input logic [11:0] py,
                                     input logic [11:0] cx, input logic [11:0] cy);
        logic [12:0] x_end;
        logic [12:0] y_end;
        x_end = {1'b0, cx} + {1'b0, CELL_P};
        y_end = {1'b0, cy} + {1'b0, CELL_P};
        return (px >= cx) && ({1'b0, px} < x_end) && (py >= cy) && ({1'b0, py} < y_end);
    endfunction

    // Reversing onto the body is not allowed, so an opposite command keeps the last heading.
    always_comb begin
        cmd_valid = 1'b0;
        cmd_dir   = DIR_RIGHT;
        case (accion)
            3'd1: begin cmd_valid = 1'b1; cmd_dir = DIR_UP;    end
            3'd2: begin cmd_valid = 1'b1; cmd_dir = DIR_DOWN;  end
            3'd3: begin cmd_valid = 1'b1; cmd_dir = DIR_LEFT;  end
            3'd4: begin cmd_valid = 1'b1; cmd_dir = DIR_RIGHT; end
            default: ;
        endcase
        eff_dir = cmd_dir;
        case (cmd_dir)
            DIR_UP:    if (last_dir == DIR_DOWN)  eff_dir = last_dir;
            DIR_DOWN:  if (last_dir == DIR_UP)    eff_dir = last_dir;
            DIR_LEFT:  if (last_dir == DIR_RIGHT) eff_dir = last_dir;
            DIR_RIGHT: if (last_dir == DIR_LEFT)  eff_dir = last_dir;
        endcase
    end

    always_comb begin
        new_x    = seg_x[0];
        new_y    = seg_y[0];
        hit_wall = 1'b0;
        case (eff_dir)
            DIR_UP:
                if (seg_y[0] == 12'd0) begin
`ifdef GAME_LOGIC_WRAP_EN
                    new_y = Y_LAST;
`else
                    hit_wall = 1'b1;
`endif
                end else begin
                    new_y = seg_y[0] - CELL_P;
                end
            DIR_DOWN:
                if (seg_y[0] >= Y_LAST) begin
`ifdef GAME_LOGIC_WRAP_EN
                    new_y = 12'd0;
`else
                    hit_wall = 1'b1;
`endif
                end else begin
                    new_y = seg_y[0] + CELL_P;
                end
            DIR_LEFT:
                if (seg_x[0] == 12'd0) begin
`ifdef GAME_LOGIC_WRAP_EN
                    new_x = X_LAST;
`else
                    hit_wall = 1'b1;
`endif
                end else begin
                    new_x = seg_x[0] - CELL_P;
                end
            DIR_RIGHT:
                if (seg_x[0] >= X_LAST) begin
`ifdef GAME_LOGIC_WRAP_EN
                    new_x = 12'd0;
`else
                    hit_wall = 1'b1;
`endif
                end else begin
                    new_x = seg_x[0] + CELL_P;
                end
        endcase
    end

    // The tail cell is vacated by a normal step, so it only counts as an obstacle when growing.
    always_comb begin
        eat       = (new_x == fruit_x) && (new_y == fruit_y);
        grow      = eat && (len < LEN_MAX);
        check_len = grow ? len : len - LEN_W'(1);
        self_hit  = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((LEN_W'(i) < check_len) && (seg_x[i] == new_x) && (seg_y[i] == new_y)) begin
                self_hit = 1'b1;
            end
        end
    end

    assign game_over = (state == ST_OVER);
    assign step_req  = mover && cmd_valid && !game_over;
    assign step_ok   = step_req && !hit_wall && !self_hit;
    assign collide   = step_req && (hit_wall || self_hit);
    assign btn       = {izquierda, derecha, arriba, abajo};
    assign btn_rise  = |(btn & ~btn_prev);
    assign restart   = game_over && btn_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_PLAY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_PLAY: if (collide)  state_next = ST_OVER;
            ST_OVER: if (btn_rise) state_next = ST_PLAY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= 12'd0;
                seg_y[i] <= 12'd0;
            end
            seg_x[0] <= X0;
            seg_x[1] <= X0 - CELL_P;
            seg_x[2] <= X0 - CELL_P - CELL_P;
            seg_y[0] <= Y0;
            seg_y[1] <= Y0;
            seg_y[2] <= Y0;
            len      <= LEN_INIT;
            last_dir <= DIR_RIGHT;
        end else if (step_ok) begin
            // Shifting the whole array leaves the old tail one slot further back, ready for growth.
            for (int i = MAX_LEN - 1; i > 0; i--) begin
                seg_x[i] <= seg_x[i-1];
                seg_y[i] <= seg_y[i-1];
            end
            seg_x[0] <= new_x;
            seg_y[0] <= new_y;
            last_dir <= eff_dir;
            if (grow) begin
                len <= len + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            comer    <= 1'b0;
            btn_prev <= 4'd0;
        end else begin
            comer    <= step_ok && eat;
            btn_prev <= btn;
        end
    end

    assign pix_x = {1'b0, pixel_x};
    assign pix_y = {1'b0, pixel_y};

    always_comb begin
        in_head  = in_cell(pix_x, pix_y, seg_x[0], seg_y[0]);
        in_fruit = in_cell(pix_x, pix_y, fruit_x, fruit_y);
        in_body  = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((LEN_W'(i) < len) && in_cell(pix_x, pix_y, seg_x[i], seg_y[i])) begin
                in_body = 1'b1;
            end
        end
    end

    // Paused head blinks white with the slow toggle; priority is head, body, fruit, background.
    always_comb begin
        rgb_next = game_over ? {3'd4, 3'd0, 2'd0} : 8'h00;
        if (in_head) begin
            rgb_next = (!cmd_valid && clk_reduced) ? {3'd7, 3'd7, 2'd3} : {3'd7, 3'd7, 2'd0};
        end else if (in_body) begin
            rgb_next = {3'd0, 3'd7, 2'd0};
        end else if (in_fruit) begin
            rgb_next = {r_fruta, g_fruta, b_fruta};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {r_out, g_out, b_out} <= 8'h00;
        end else begin
            {r_out, g_out, b_out} <= rgb_next;
        end
    end

endmodule

// File: tb/tb_game_logic.sv
// Scoreboard bench for game_logic: stimulus queues expected colour/comer, a monitor checks them.
// Expectations follow GAME_LOGIC_WRAP_EN when it is defined for the build.
module tb_game_logic;

    localparam logic [7:0] YEL = 8'hFC;
    localparam logic [7:0] WHT = 8'hFF;
    localparam logic [7:0] GRN = 8'h1C;
    localparam logic [7:0] RED = 8'h80;
    localparam logic [7:0] BLK = 8'h00;
    localparam logic [7:0] FRU = 8'h29;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_reduced;
    logic        mover;
    logic [10:0] pixel_x;
    logic [10:0] pixel_y;
    logic        izquierda;
    logic        derecha;
    logic        arriba;
    logic        abajo;
    logic [2:0]  accion;
    logic [2:0]  r_fruta;
    logic [2:0]  g_fruta;
    logic [1:0]  b_fruta;
    logic [11:0] fruit_x;
    logic [11:0] fruit_y;
    logic [2:0]  r_out;
    logic [2:0]  g_out;
    logic [1:0]  b_out;
    logic        comer;

    typedef struct {
        string      name;
        logic       chk_rgb;
        logic [7:0] rgb;
        logic       chk_comer;
        logic       comer;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run = 0;
    int   failures  = 0;
    logic probe     = 1'b0;
    logic probe_d   = 1'b0;

    always #5 clk = ~clk;

    game_logic #(.MAX_LEN(16), .CELL(20)) dut (
        .clk(clk), .rst(rst), .clk_reduced(clk_reduced), .mover(mover),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .izquierda(izquierda), .derecha(derecha), .arriba(arriba), .abajo(abajo),
        .accion(accion), .r_fruta(r_fruta), .g_fruta(g_fruta), .b_fruta(b_fruta),
        .fruit_x(fruit_x), .fruit_y(fruit_y),
        .r_out(r_out), .g_out(g_out), .b_out(b_out), .comer(comer)
    );

    always @(posedge clk) probe_d <= probe;

    task automatic checkOutput(input exp_t e);
        if (e.chk_rgb) begin
            tests_run++;
            if ({r_out, g_out, b_out} !== e.rgb) begin
                failures++;
                $display("[TB] FAIL %s: rgb got %h expected %h", e.name, {r_out, g_out, b_out}, e.rgb);
            end
        end
        if (e.chk_comer) begin
            tests_run++;
            if (comer !== e.comer) begin
                failures++;
                $display("[TB] FAIL %s: comer got %b expected %b", e.name, comer, e.comer);
            end
        end
    endtask

    // Monitor: one cycle after a probe the registered outputs belong to that probe.
    always @(negedge clk) begin
        if (probe_d) begin
            if (sb_q.size() == 0) begin
                tests_run++;
                failures++;
                $display("[TB] FAIL scoreboard_underflow: got output with no expectation queued");
            end else begin
                checkOutput(sb_q.pop_front());
            end
        end
    end

    task automatic applyStimulus(input logic mv, input logic [2:0] act, input int px, input int py,
                                 input string nm, input logic crgb, input logic [7:0] ergb,
                                 input logic ccom, input logic ecom);
        exp_t e;
        mover   = mv;
        accion  = act;
        pixel_x = 11'(px);
        pixel_y = 11'(py);
        e.name      = nm;
        e.chk_rgb   = crgb;
        e.rgb       = ergb;
        e.chk_comer = ccom;
        e.comer     = ecom;
        if (crgb || ccom) begin
            sb_q.push_back(e);
            probe = 1'b1;
        end
        @(posedge clk);
        #1;
        mover = 1'b0;
        probe = 1'b0;
    endtask

    task automatic probePix(input int px, input int py, input string nm, input logic [7:0] ergb);
        applyStimulus(1'b0, 3'd0, px, py, nm, 1'b1, ergb, 1'b0, 1'b0);
    endtask

    task automatic stepChk(input logic [2:0] act, input string nm, input logic ecom);
        applyStimulus(1'b1, act, 0, 0, nm, 1'b0, 8'h00, 1'b1, ecom);
    endtask

    task automatic pulse(input logic mv, input logic [2:0] act);
        applyStimulus(mv, act, 0, 0, "", 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Reset is applied together with a step request so the reset must win.
    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b1, 3'd1, 405, 305, "reset_out", 1'b1, BLK, 1'b1, 1'b0);
        pulse(1'b0, 3'd0);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1; clk_reduced = 1'b0; mover = 1'b0; accion = 3'd0;
        pixel_x = 11'd0; pixel_y = 11'd0;
        izquierda = 1'b0; derecha = 1'b0; arriba = 1'b0; abajo = 1'b0;
        r_fruta = 3'd1; g_fruta = 3'd2; b_fruta = 2'd1;
        fruit_x = 12'd700; fruit_y = 12'd500;

        // Reset image, cell boundaries, fruit, blink, then up step and a refused reversal.
        doReset();
        probePix(405, 305, "head_after_reset", YEL);
        probePix(385, 305, "seg1_after_reset", GRN);
        probePix(365, 305, "seg2_after_reset", GRN);
        probePix(345, 305, "beyond_tail", BLK);
        probePix(5, 5, "unused_seg_hidden", BLK);
        probePix(419, 319, "head_cell_corner", YEL);
        probePix(420, 305, "head_cell_right_edge", BLK);
        probePix(405, 320, "head_cell_bottom_edge", BLK);
        probePix(705, 505, "fruit_colour", FRU);
        probePix(720, 505, "fruit_cell_edge", BLK);
        clk_reduced = 1'b1;
        probePix(405, 305, "head_blink_white", WHT);
        clk_reduced = 1'b0;
        stepChk(3'd1, "up_step_comer", 1'b0);
        probePix(405, 285, "up_head", YEL);
        probePix(405, 305, "up_seg1", GRN);
        probePix(385, 305, "up_seg2", GRN);
        probePix(365, 305, "up_old_tail_gone", BLK);
        stepChk(3'd2, "down_reversal_step", 1'b0);
        probePix(405, 265, "reversal_keeps_up", YEL);
        probePix(405, 285, "reversal_seg1", GRN);

        // Eat, reversal while heading right, and steps that must not move.
        doReset();
        fruit_x = 12'd420; fruit_y = 12'd300;
        stepChk(3'd4, "eat_comer_pulse", 1'b1);
        applyStimulus(1'b0, 3'd0, 425, 305, "eat_head_comer_low", 1'b1, YEL, 1'b1, 1'b0);
        fruit_x = 12'd700; fruit_y = 12'd500;
        probePix(365, 305, "grown_tail_kept", GRN);
        stepChk(3'd3, "left_reversal_step", 1'b0);
        probePix(445, 305, "reversal_keeps_right", YEL);
        probePix(365, 305, "tail_followed", BLK);
        probePix(385, 305, "len4_tail", GRN);
        pulse(1'b1, 3'd0);
        pulse(1'b1, 3'd5);
        pulse(1'b0, 3'd4);
        probePix(445, 305, "hold_head", YEL);
        probePix(465, 305, "hold_no_advance", BLK);

        // Run into the right wall.
        doReset();
        repeat (19) pulse(1'b1, 3'd4);
        probePix(785, 305, "head_at_right_edge", YEL);
`ifdef GAME_LOGIC_WRAP_EN
        stepChk(3'd4, "wrap_step", 1'b0);
        probePix(5, 305, "wrap_head", YEL);
        probePix(785, 305, "wrap_seg1", GRN);
        probePix(405, 105, "wrap_no_gameover_bg", BLK);
`else
        stepChk(3'd4, "wall_step", 1'b0);
        probePix(5, 5, "gameover_bg", RED);
        probePix(785, 305, "wall_head_unchanged", YEL);
        stepChk(3'd2, "frozen_step", 1'b0);
        probePix(785, 325, "frozen_no_move", RED);
        arriba = 1'b1;
        pulse(1'b0, 3'd0);
        arriba = 1'b0;
        probePix(405, 305, "restart_head", YEL);
        probePix(785, 305, "restart_old_head_gone", BLK);
        probePix(5, 5, "restart_bg_black", BLK);
`endif

        // Grow to five, turn back into the body, restart, then reset during a step.
        doReset();
        fruit_x = 12'd420; fruit_y = 12'd300;
        stepChk(3'd4, "grow1_comer", 1'b1);
        fruit_x = 12'd440; fruit_y = 12'd300;
        stepChk(3'd4, "grow2_comer", 1'b1);
        fruit_x = 12'd700; fruit_y = 12'd500;
        probePix(365, 305, "len5_tail", GRN);
        pulse(1'b1, 3'd2);
        pulse(1'b1, 3'd3);
        stepChk(3'd1, "self_collide_step", 1'b0);
        probePix(5, 5, "self_collide_bg", RED);
        probePix(425, 325, "self_collide_head_kept", YEL);
        abajo = 1'b1;
        pulse(1'b0, 3'd0);
        abajo = 1'b0;
        probePix(405, 305, "restart2_head", YEL);
        probePix(5, 5, "restart2_bg", BLK);
        pulse(1'b1, 3'd1);
        doReset();
        probePix(405, 305, "rst_beats_step_head", YEL);
        probePix(405, 285, "rst_beats_step_no_up", BLK);

        repeat (3) @(posedge clk);
        #1;
        if (sb_q.size() != 0) begin
            tests_run++;
            failures++;
            $display("[TB] FAIL scoreboard_drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
